tx_redundancy_scheduler: RTL
============================

// Module: tx_redundancy_scheduler
// PURPOSE
//  Sequences one video frame's transmission on the 125 MHz Ethernet TX side. Pass txid=1 sends segments
//  0..seg_count-1 live and stores each payload in its per-segment BRAM. Passes txid=2..redundancy resend
//  the same segments from BRAM. Drives txid/segment_num and the BRAM write/read address counters of
//  tx_memory_control. Issues per-packet starts to byte_data; enforces inter-packet gap and done-timeout.
// PARAMETERS
//  SEGMENT_NUMBER_MAX  150    number of segment BRAMs; seg_count clamps to this
//  PAYLOAD_MAX         8192   payload bytes per segment; 13-bit address space
//  WR_DELAY            3      cycles from read address to write address/enable (tx_memory_control latency)
//  GAP_CYCLES          12     idle cycles between pkt_done and next pkt_start (min 1)
//  TIMEOUT_CYCLES      65535  max cycles waiting for pkt_done before abort
// PORTS
//  clk125MHz          in   1   Ethernet TX clock, sole clock
//  rst                in   1   synchronous, active-high reset
//  frame_start        in   1   1-cycle pulse: begin a frame
//  redundancy         in   8   passes per frame, sampled at frame_start; 0 treated as 1
//  seg_count          in   16  segments per frame, sampled at frame_start; 0 = no-op; >MAX clamps to MAX
//  pkt_done           in   1   1-cycle pulse from byte_data: packet fully sent
//  data_user          in   1   byte_data payload-active strobe; high one cycle per payload byte
//  txid               out  8   current pass, 1..redundancy; 0 when idle
//  segment_num        out  16  current segment, 0..seg_count-1
//  pkt_start          out  1   1-cycle pulse to byte_data
//  count_for_bram_b   out  13  BRAM read address (byte index in payload)
//  count_for_bram     out  13  count_for_bram_b delayed WR_DELAY cycles
//  count_for_bram_en  out  1   data_user delayed WR_DELAY cycles
//  busy               out  1   high from accepted frame_start until frame_done
//  frame_done         out  1   1-cycle pulse after last packet's gap completes, or on abort
//  err_timeout        out  1   sticky; cleared at next accepted frame_start
//  err_overrun        out  1   sticky: data_user high at address PAYLOAD_MAX-1; cleared likewise
// BEHAVIOUR
//  Reset: FSM=IDLE; txid=0, segment_num=0, all counters/delay lines 0, all pulses/flags 0, busy=0.
//  FSM: IDLE -> START on frame_start with seg_count!=0. IDLE: frame_start with seg_count==0 pulses
//   frame_done next cycle; state stays IDLE.
//   START: pkt_start=1 one cycle, clear rd counter and timeout counter -> WAIT.
//   WAIT: on pkt_done -> GAP. If timeout counter reaches TIMEOUT_CYCLES -> IDLE; set err_timeout;
//   pulse frame_done.
//   GAP: count GAP_CYCLES. Then advance (segment inner, txid outer) -> START, or -> DONE after last pair.
//   DONE: frame_done=1 one cycle; txid=0 -> IDLE.
//  Advance: segment_num+1; at seg_count-1 wrap to 0 and txid+1. Last pair: txid==R, seg==seg_count-1.
//  txid/segment_num registered; change only on GAP exit; stable from pkt_start until pkt_done.
//  frame_start while busy: ignored; latched redundancy/seg_count unchanged.
//  pkt_done outside WAIT: ignored. pkt_done and timeout expiry in the same cycle: pkt_done wins.
//  Read counter: increments on each data_user cycle; saturates at PAYLOAD_MAX-1 and sets err_overrun.
//  Write path: WR_DELAY-stage shift register on {count, data_user}; stages cleared only by rst.
//  Reset mid-frame: everything returns to reset values next cycle; no frame_done pulse.
// STRUCTURE
//  Shared package tx_pkg: state enum (IDLE, START, WAIT, GAP, DONE); constants
//   SEGMENT_NUMBER_MAX, PAYLOAD_MAX, BRAM_AW=13.
//  Sub-module tx_addr_pipe: read counter, saturation, WR_DELAY delay line.
//  FSM, pass/segment counters and gap/timeout counters live in the top module.
// TESTING
//  R=3, seg_count=4, pkt_done 50 cycles after each pkt_start -> 12 pkt_starts.
//   Order (txid,seg): (1,0..3),(2,0..3),(3,0..3); one frame_done; busy low after it.
//  redundancy=0, seg_count=2 -> 2 packets, both txid=1. seg_count=0 -> frame_done next cycle;
//   no pkt_start.
//  data_user 10 cycles after pkt_start -> count_for_bram_b 0..9. count_for_bram/en repeat the same
//   values 3 cycles later.
//  pkt_done withheld (TIMEOUT_CYCLES=100) -> err_timeout set, frame_done pulses, IDLE.
//   Next frame_start clears err_timeout.
//  frame_start during busy -> ignored, packet count unchanged. rst mid-WAIT -> all outputs 0 next
//   cycle; no frame_done.
//  PAYLOAD_MAX=16, 20 data_user cycles -> count_for_bram_b stops at 15; err_overrun=1.

Source files
------------

// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared state encoding and sizing constants for the TX redundancy scheduler
package tx_pkg;

    localparam int SEGMENT_NUMBER_MAX = 150;
    localparam int PAYLOAD_MAX        = 8192;
    localparam int BRAM_AW            = 13;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        GAP,
        DONE
    } tx_state_t;

endpackage

// File: rtl/tx_addr_pipe.sv
// rtl/tx_addr_pipe.sv - payload read address counter with saturation and write-side delay line
module tx_addr_pipe #(
    parameter int PAYLOAD_MAX = tx_pkg::PAYLOAD_MAX,
    parameter int WR_DELAY    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       data_user,
    output logic [tx_pkg::BRAM_AW-1:0] rd_addr,
    output logic [tx_pkg::BRAM_AW-1:0] wr_addr,
    output logic                       wr_en,
    output logic                       overrun
);

    localparam int AW = tx_pkg::BRAM_AW;
    localparam logic [AW-1:0] ADDR_LAST = AW'(PAYLOAD_MAX - 1);

    logic [AW:0] stage [WR_DELAY];

    // A byte requested at the last address has nowhere to go; flag it and hold the address.
    assign overrun = data_user && (rd_addr == ADDR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr <= '0;
        end else if (clr) begin
            rd_addr <= '0;
        end else if (data_user && (rd_addr != ADDR_LAST)) begin
            rd_addr <= rd_addr + AW'(1);
        end
    end

    // Delay line is only cleared by reset so an in-flight write always completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WR_DELAY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= {data_user, rd_addr};
            for (int i = 1; i < WR_DELAY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign {wr_en, wr_addr} = stage[WR_DELAY-1];

endmodule

// File: rtl/tx_redundancy_scheduler.sv
// rtl/tx_redundancy_scheduler.sv - sequences live and BRAM-replayed passes of one frame's segments
module tx_redundancy_scheduler #(
    parameter int SEGMENT_NUMBER_MAX = tx_pkg::SEGMENT_NUMBER_MAX,
    parameter int PAYLOAD_MAX        = tx_pkg::PAYLOAD_MAX,
    parameter int WR_DELAY           = 3,
    parameter int GAP_CYCLES         = 12,
    parameter int TIMEOUT_CYCLES     = 65535
) (
    input  logic                       clk125MHz,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic [7:0]                 redundancy,
    input  logic [15:0]                seg_count,
    input  logic                       pkt_done,
    input  logic                       data_user,
    output logic [7:0]                 txid,
    output logic [15:0]                segment_num,
    output logic                       pkt_start,
    output logic [tx_pkg::BRAM_AW-1:0] count_for_bram_b,
    output logic [tx_pkg::BRAM_AW-1:0] count_for_bram,
    output logic                       count_for_bram_en,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       err_timeout,
    output logic                       err_overrun
);

    import tx_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    tx_state_t     state;
    tx_state_t     state_nxt;
    logic [7:0]    red_lat;
    logic [15:0]   seg_lat;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] gap_cnt;
    logic          frame_done_q;
    logic          overrun_hit;
    logic          accept;
    logic          tmo_hit;
    logic          gap_end;
    logic          last_seg;
    logic          last_pass;

    assign accept    = (state == IDLE) && frame_start && (seg_count != 16'd0);
    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign gap_end   = (gap_cnt == GW'(GAP_CYCLES - 1));
    assign last_seg  = (segment_num == seg_lat - 16'd1);
    assign last_pass = (txid == red_lat);

    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // pkt_done is checked before the timeout so a completion on the final cycle still counts.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = START;
            START: state_nxt = WAIT;
            WAIT: begin
                if (pkt_done) begin
                    state_nxt = GAP;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            GAP:   if (gap_end) state_nxt = (last_seg && last_pass) ? DONE : START;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pkt_start  = (state == START);
        busy       = (state != IDLE);
        frame_done = (state == DONE) || frame_done_q;
    end

    // Segment index is the inner loop, pass index the outer one; both move only on gap exit.
    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            txid         <= '0;
            segment_num  <= '0;
            red_lat      <= '0;
            seg_lat      <= '0;
            tmo_cnt      <= '0;
            gap_cnt      <= '0;
            frame_done_q <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (overrun_hit) begin
                err_overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        err_timeout <= 1'b0;
                        err_overrun <= 1'b0;
                        if (seg_count == 16'd0) begin
                            frame_done_q <= 1'b1;
                        end else begin
                            red_lat     <= (redundancy == 8'd0) ? 8'd1 : redundancy;
                            seg_lat     <= (seg_count > 16'(SEGMENT_NUMBER_MAX)) ?
                                           16'(SEGMENT_NUMBER_MAX) : seg_count;
                            txid        <= 8'd1;
                            segment_num <= '0;
                        end
                    end
                end
                START: begin
                    tmo_cnt <= '0;
                    gap_cnt <= '0;
                end
                WAIT: begin
                    if (pkt_done) begin
                        gap_cnt <= '0;
                    end else if (tmo_hit) begin
                        err_timeout  <= 1'b1;
                        frame_done_q <= 1'b1;
                        txid         <= '0;
                        segment_num  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        if (last_seg) begin
                            segment_num <= '0;
                            if (!last_pass) begin
                                txid <= txid + 8'd1;
                            end
                        end else begin
                            segment_num <= segment_num + 16'd1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                DONE: begin
                    txid        <= '0;
                    segment_num <= '0;
                end
                default: ;
            endcase
        end
    end

    tx_addr_pipe #(
        .PAYLOAD_MAX (PAYLOAD_MAX),
        .WR_DELAY    (WR_DELAY)
    ) u_addr_pipe (
        .clk       (clk125MHz),
        .rst       (rst),
        .clr       (state == START),
        .data_user (data_user),
        .rd_addr   (count_for_bram_b),
        .wr_addr   (count_for_bram),
        .wr_en     (count_for_bram_en),
        .overrun   (overrun_hit)
    );

endmodule
